// File: rtl/rvx_gpio_debouncer_pkg.sv
// rvx_gpio_debounce_pkg: default sizing constants and the counter-width
// helper shared by the GPIO debouncer top and its per-bit slice.
package rvx_gpio_debounce_pkg;

    localparam int DEF_GPIO_WIDTH   = 32;
    localparam int DEF_TICK_DIVIDER = 50000;
    localparam int DEF_STABLE_TICKS = 4;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rvx_gpio_debouncer_if.sv
// rvx_gpio_debouncer_if: pad-side inputs and filtered outputs of the
// GPIO debouncer, with master (SoC side) and slave (debouncer) views.
interface rvx_gpio_debouncer_if #(
    parameter int GPIO_WIDTH = 32
);

    logic [GPIO_WIDTH-1:0] gpio_raw;
    logic [GPIO_WIDTH-1:0] edge_clear;
    logic [GPIO_WIDTH-1:0] gpio_debounced;
    logic [GPIO_WIDTH-1:0] rise_pulse;
    logic [GPIO_WIDTH-1:0] fall_pulse;
    logic [GPIO_WIDTH-1:0] edge_pending;
    logic                  irq;

    modport master (
        output gpio_raw,
        output edge_clear,
        input  gpio_debounced,
        input  rise_pulse,
        input  fall_pulse,
        input  edge_pending,
        input  irq
    );

    modport slave (
        input  gpio_raw,
        input  edge_clear,
        output gpio_debounced,
        output rise_pulse,
        output fall_pulse,
        output edge_pending,
        output irq
    );

endinterface

// File: rtl/rvx_gpio_debounce_bit.sv
// rvx_gpio_debounce_bit: one pad bit -- synchronizer, stability counter,
// accepted level, edge pulses and (with RVX_GPIO_EDGE_IRQ_EN) sticky flag.
module rvx_gpio_debounce_bit
    import rvx_gpio_debounce_pkg::*;
#(
    parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    input  logic clear,
    output logic debounced,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic edge_pending
);

    localparam int CW = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_TICKS - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          sync;

    assign sync = sync_q[1];

    // Two-flop synchronizer for the asynchronous pad input.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], raw};
        end
    end

    // Count ticks of disagreement; accept the new level on the last one.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q      <= '0;
            debounced  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            if (sync == debounced) begin
                cnt_q <= '0;
            end else if (tick) begin
                if (cnt_q == CNT_MAX) begin
                    cnt_q      <= '0;
                    debounced  <= sync;
                    rise_pulse <= sync;
                    fall_pulse <= ~sync;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

`ifdef RVX_GPIO_EDGE_IRQ_EN
    // Sticky edge flag; a new edge beats a coincident clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            edge_pending <= 1'b0;
        end else if (rise_pulse || fall_pulse) begin
            edge_pending <= 1'b1;
        end else if (clear) begin
            edge_pending <= 1'b0;
        end
    end
`else
    logic unused_clear;
    assign unused_clear = clear;
    assign edge_pending = 1'b0;
`endif

endmodule

// File: rtl/rvx_gpio_debouncer.sv
// rvx_gpio_debouncer: shared sample-tick prescaler plus one debounce slice
// per GPIO bit. Define RVX_GPIO_EDGE_IRQ_EN for sticky edge flags and irq.
module rvx_gpio_debouncer
    import rvx_gpio_debounce_pkg::*;
#(
    parameter int GPIO_WIDTH   = DEF_GPIO_WIDTH,
    parameter int TICK_DIVIDER = DEF_TICK_DIVIDER,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
    input logic                   clock,
    input logic                   reset,
    rvx_gpio_debouncer_if.slave   bus
);

    localparam int PW = cnt_width(TICK_DIVIDER);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIVIDER - 1);

    logic [PW-1:0] pre_q;
    logic          tick;

    assign tick = (pre_q == PRE_MAX);

    // Free-running prescaler wrapping at the divider terminal count.
    always_ff @(posedge clock) begin
        if (reset) begin
            pre_q <= '0;
        end else if (tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

    for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_bit
        rvx_gpio_debounce_bit #(
            .STABLE_TICKS (STABLE_TICKS)
        ) u_bit (
            .clock        (clock),
            .reset        (reset),
            .tick         (tick),
            .raw          (bus.gpio_raw[i]),
            .clear        (bus.edge_clear[i]),
            .debounced    (bus.gpio_debounced[i]),
            .rise_pulse   (bus.rise_pulse[i]),
            .fall_pulse   (bus.fall_pulse[i]),
            .edge_pending (bus.edge_pending[i])
        );
    end

    assign bus.irq = |bus.edge_pending;

endmodule

// File: tb/tb_rvx_gpio_debouncer.sv
// tb_rvx_gpio_debouncer: table-driven vectors through a scoreboard queue,
// for a divider-1 and a divider-4 instance of the debouncer.
module tb_rvx_gpio_debouncer;

    typedef struct {
        logic       rst;
        logic [3:0] raw;
        logic [3:0] clr;
        logic [3:0] deb;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] pend;
    } vec_t;

    logic clk = 1'b0;
    logic rst1 = 1'b1;
    logic rst4 = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t tbl[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    rvx_gpio_debouncer_if #(.GPIO_WIDTH(4)) bus1 ();
    rvx_gpio_debouncer_if #(.GPIO_WIDTH(4)) bus4 ();

    rvx_gpio_debouncer #(
        .GPIO_WIDTH   (4),
        .TICK_DIVIDER (1),
        .STABLE_TICKS (3)
    ) dut (
        .clock (clk),
        .reset (rst1),
        .bus   (bus1.slave)
    );

    rvx_gpio_debouncer #(
        .GPIO_WIDTH   (4),
        .TICK_DIVIDER (4),
        .STABLE_TICKS (3)
    ) dut4 (
        .clock (clk),
        .reset (rst4),
        .bus   (bus4.slave)
    );

    function automatic logic [3:0] pe(input logic [3:0] x);
`ifdef RVX_GPIO_EDGE_IRQ_EN
        return x;
`else
        return 4'b0000 & x;
`endif
    endfunction

    function automatic vec_t mk(input logic r, input logic [3:0] raw,
                                input logic [3:0] clr, input logic [3:0] deb,
                                input logic [3:0] rise, input logic [3:0] fall,
                                input logic [3:0] pend);
        vec_t v;
        v.rst  = r;
        v.raw  = raw;
        v.clr  = clr;
        v.deb  = deb;
        v.rise = rise;
        v.fall = fall;
        v.pend = pe(pend);
        return v;
    endfunction

    task automatic chk(input string name, input int cyc,
                       input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %b expected %b",
                     name, cyc, act, exp);
        end
    endtask

    task automatic apply(input bit on4, input int cyc, input vec_t v);
        vec_t e;
        @(posedge clk);
        #1;
        if (on4) begin
            rst4 = v.rst;
            bus4.gpio_raw = v.raw;
            bus4.edge_clear = v.clr;
        end else begin
            rst1 = v.rst;
            bus1.gpio_raw = v.raw;
            bus1.edge_clear = v.clr;
        end
        exp_q.push_back(v);
        @(negedge clk);
        e = exp_q.pop_front();
        if (on4) begin
            chk("deb4", cyc, bus4.gpio_debounced, e.deb);
            chk("rise4", cyc, bus4.rise_pulse, e.rise);
            chk("fall4", cyc, bus4.fall_pulse, e.fall);
            chk("pend4", cyc, bus4.edge_pending, e.pend);
            chk("irq4", cyc, {3'b0, bus4.irq}, {3'b0, |e.pend});
        end else begin
            chk("deb", cyc, bus1.gpio_debounced, e.deb);
            chk("rise", cyc, bus1.rise_pulse, e.rise);
            chk("fall", cyc, bus1.fall_pulse, e.fall);
            chk("pend", cyc, bus1.edge_pending, e.pend);
            chk("irq", cyc, {3'b0, bus1.irq}, {3'b0, |e.pend});
        end
    endtask

    initial begin
        bus1.gpio_raw = '0;
        bus1.edge_clear = '0;
        bus4.gpio_raw = '0;
        bus4.edge_clear = '0;

        // reset, then bit0 rises (pulse at cycle 5), bit1 glitch,
        // clear, then bit0 falls with a clear coincident with the pulse
        tbl.push_back(mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
        tbl.push_back(mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
        for (int c = 0; c < 5; c++)
            tbl.push_back(mk(0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
        tbl.push_back(mk(0, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0));
        tbl.push_back(mk(0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1));
        tbl.push_back(mk(0, 4'h3, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1));
        tbl.push_back(mk(0, 4'h3, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1));
        for (int c = 9; c < 13; c++)
            tbl.push_back(mk(0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1));
        tbl.push_back(mk(0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h1));
        tbl.push_back(mk(0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0));
        for (int c = 15; c < 20; c++)
            tbl.push_back(mk(0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0));
        tbl.push_back(mk(0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1));
        tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1));

        foreach (tbl[i])
            apply(1'b0, i - 2, tbl[i]);

        // bit3 reset while its count sits at 2, held high through release
        for (int k = 0; k < 4; k++)
            apply(1'b0, 100 + k, mk(0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1));
        apply(1'b0, 104, mk(1, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1));
        apply(1'b0, 105, mk(1, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
        for (int k = 0; k < 9; k++)
            apply(1'b0, 200 + k,
                  mk(0, 4'h8, 4'h0,
                     (k >= 5) ? 4'h8 : 4'h0,
                     (k == 5) ? 4'h8 : 4'h0,
                     4'h0,
                     (k >= 6) ? 4'h8 : 4'h0));

        // divider 4: tick every 4th cycle, bit2 accepted at cycle 12
        apply(1'b1, 298, mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
        apply(1'b1, 299, mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
        for (int k = 0; k < 16; k++)
            apply(1'b1, 300 + k,
                  mk(0, 4'h4, 4'h0,
                     (k >= 12) ? 4'h4 : 4'h0,
                     (k == 12) ? 4'h4 : 4'h0,
                     4'h0,
                     (k >= 13) ? 4'h4 : 4'h0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rvx_gpio_debouncer.md
RVX_GPIO_DEBOUNCER -- requirements
Module: rvx_gpio_debouncer

Interface
REQ-001 Parameter GPIO_WIDTH, default 32, number of independent input bits.
REQ-002 Parameter TICK_DIVIDER, default 50000, clock cycles per sample tick (1 ms at 50 MHz); legal range >= 1.
REQ-003 Parameter STABLE_TICKS, default 4, consecutive mismatching ticks required to accept a new level; legal range >= 1.
REQ-004 clock  input  1  single system clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 gpio_raw  input  GPIO_WIDTH  asynchronous pad inputs.
REQ-007 gpio_debounced  output  GPIO_WIDTH  filtered levels; drives the SoC gpio_input port.
REQ-008 rise_pulse  output  GPIO_WIDTH  one-cycle pulse per bit on accepted 0->1 change.
REQ-009 fall_pulse  output  GPIO_WIDTH  one-cycle pulse per bit on accepted 1->0 change.
REQ-010 edge_clear  input  GPIO_WIDTH  per-bit write-one-to-clear for edge_pending.
REQ-011 edge_pending  output  GPIO_WIDTH  sticky per-bit edge flags.
REQ-012 irq  output  1  OR-reduction of edge_pending.

Function
REQ-013 Each gpio_raw bit SHALL pass through a two-flop synchronizer; sync output lags gpio_raw by 2 cycles.
REQ-014 One shared prescaler SHALL count 0..TICK_DIVIDER-1, assert tick for exactly one cycle at TICK_DIVIDER-1, then wrap to 0; TICK_DIVIDER=1 gives tick every cycle.
REQ-015 Per bit, any cycle where sync equals gpio_debounced SHALL clear that bit's stability counter (width clog2(STABLE_TICKS), min 1).
REQ-016 Per bit, on tick with sync != gpio_debounced and counter < STABLE_TICKS-1, counter SHALL increment by 1.
REQ-017 Per bit, on tick with sync != gpio_debounced and counter == STABLE_TICKS-1, gpio_debounced SHALL toggle next edge and counter SHALL clear; counter never wraps.
REQ-018 rise_pulse/fall_pulse SHALL be registered, high in the same cycle gpio_debounced first shows the new level, low otherwise.
REQ-019 Glitch returning to the debounced level before STABLE_TICKS ticks SHALL produce no change and no pulse.
REQ-020 edge_pending bit SHALL set on its rise or fall pulse and clear when edge_clear bit is 1; simultaneous set and clear: set wins.
REQ-021 irq SHALL be registered-free combinational OR of edge_pending (no extra latency).
REQ-022 Bits SHALL be fully independent except for the shared tick.

Reset
REQ-023 While reset=1: synchronizer flops, prescaler, counters, gpio_debounced, rise_pulse, fall_pulse, edge_pending all 0; irq 0.
REQ-024 Reset asserted mid-count SHALL discard partial counts; a bit held high through reset release SHALL debounce from 0 and emit one rise_pulse.

Configuration
REQ-025 Macro RVX_GPIO_EDGE_IRQ_EN defined: edge_pending, edge_clear, irq behave per REQ-020/021.
REQ-026 Macro undefined: edge_pending and irq tied 0, edge_clear ignored, no pending flops synthesized; pulses and debounce unchanged.

Structure
REQ-027 Package rvx_gpio_debounce_pkg SHALL hold default constants (GPIO_WIDTH, TICK_DIVIDER, STABLE_TICKS) and the counter-width function.
REQ-028 Per-bit logic (synchronizer, counter, level, pulses, pending) SHALL be sub-module rvx_gpio_debounce_bit, instantiated GPIO_WIDTH times; prescaler stays in top.

Verification (bench uses GPIO_WIDTH=4, TICK_DIVIDER=1, STABLE_TICKS=3 unless stated)
REQ-029 gpio_raw 0000->0001 at cycle 0, held -> gpio_debounced=0001 and rise_pulse[0]=1 at cycle 5 only; edge_pending=0001, irq=1.
REQ-030 gpio_raw bit1 high for 2 cycles then low -> gpio_debounced, pulses, edge_pending unchanged at 0.
REQ-031 edge_pending=0001, edge_clear=0001 one cycle -> edge_pending=0000, irq=0 next cycle; clear coincident with new fall_pulse[0] -> bit stays 1.
REQ-032 TICK_DIVIDER=4: raw bit2 high held -> tick every 4th cycle, gpio_debounced[2] rises after exactly 3 ticks past sync; fall_pulse never asserts.
REQ-033 reset pulsed while bit3 count=2 -> all outputs 0; raw still high -> rise_pulse[3] exactly once, 5 cycles after reset release.
REQ-034 Build without RVX_GPIO_EDGE_IRQ_EN, REQ-029 stimulus -> same debounced/pulse timing, edge_pending=0000, irq=0 throughout.
